// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath widths, ALU op codes and EX-stage register layout
package datapath_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int ALU_W  = 4;

   localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1001;
   localparam logic [ALU_W-1:0] ALU_LUI  = 4'b1110;
   localparam logic [ALU_W-1:0] ALU_ZERO = 4'b1111;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [ALU_W-1:0]  alu_sel;
      logic [REG_W-1:0]  rd;
      logic              reg_write;
      logic              mem_read;
   } ex_regs_t;

   localparam ex_regs_t EX_REGS_RESET = '{a: '0, b: '0, alu_sel: ALU_ZERO, rd: '0,
                                          reg_write: 1'b0, mem_read: 1'b0};

   // r0 is hardwired, so a producer targeting it never supplies a forwarded value
   function automatic logic fwd_hit(input logic we, input logic [REG_W-1:0] src_rd,
                                    input logic [REG_W-1:0] addr);
      return we && (src_rd == addr) && (src_rd != '0);
   endfunction
endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - per-operand forwarding select, EX/MEM over MEM/WB over register file
module fwd_unit
   import datapath_pkg::*;
(
   input  logic [REG_W-1:0]  addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              exmem_reg_write,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_res,
   input  logic              memwb_reg_write,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] fwd_data
);
   always_comb begin
      fwd_data = rf_data;
      if (fwd_hit(exmem_reg_write, exmem_rd, addr)) begin
         fwd_data = exmem_res;
      end else if (fwd_hit(memwb_reg_write, memwb_rd, addr)) begin
         fwd_data = memwb_data;
      end
   end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [REG_W-1:0]  id_rs_addr,
   input  logic [REG_W-1:0]  id_rt_addr,
   input  logic [REG_W-1:0]  id_rd_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [ALU_W-1:0]  id_alu_sel,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_res,
   input  logic              memwb_reg_write,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [ALU_W-1:0]  ex_alu_sel,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [15:0]       bubble_cnt
);
   ex_regs_t          regs_q, regs_d;
   logic              valid_q, valid_d;
   logic [15:0]       bubble_cnt_q, bubble_cnt_d;
   logic [DATA_W-1:0] rs_fwd, rt_fwd;
   logic              hazard, stall;

   fwd_unit u_fwd_rs (
      .addr(id_rs_addr), .rf_data(id_rs_data),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .fwd_data(rs_fwd)
   );

   fwd_unit u_fwd_rt (
      .addr(id_rt_addr), .rf_data(id_rt_data),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .fwd_data(rt_fwd)
   );

   // A load in EX cannot forward its data yet; rt only matters when it is a real operand
   assign hazard = valid_q && regs_q.mem_read && (regs_q.rd != '0) &&
                   ((regs_q.rd == id_rs_addr) || (!id_use_imm && (regs_q.rd == id_rt_addr)));
   assign stall    = valid_q && !ex_ready;
   assign id_ready = !stall && !hazard;

   always_comb begin
      regs_d       = regs_q;
      valid_d      = valid_q;
      bubble_cnt_d = bubble_cnt_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else if (hazard) begin
         valid_d = 1'b0;
         if (bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
         end
      end else if (id_valid) begin
         valid_d           = 1'b1;
         regs_d.a          = rs_fwd;
         regs_d.b          = id_use_imm ? id_imm : rt_fwd;
         regs_d.alu_sel    = id_alu_sel;
         regs_d.rd         = id_rd_addr;
         regs_d.reg_write  = id_reg_write;
         regs_d.mem_read   = id_mem_read;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q       <= EX_REGS_RESET;
         valid_q      <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         regs_q       <= regs_d;
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_a         = regs_q.a;
   assign ex_b         = regs_q.b;
   assign ex_alu_sel   = regs_q.alu_sel;
   assign ex_rd        = regs_q.rd;
   assign ex_reg_write = valid_q && regs_q.reg_write;
   assign ex_mem_read  = valid_q && regs_q.mem_read;
   assign bubble_cnt   = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed checks of id_ex_stage against a reference model
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_use_imm;
   logic [3:0]  id_alu_sel;
   logic        id_reg_write, id_mem_read, flush;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_res, memwb_data;
   logic        ex_ready, ex_valid;
   logic [31:0] ex_a, ex_b;
   logic [3:0]  ex_alu_sel;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read;
   logic [15:0] bubble_cnt;

   int total = 0;
   int bad   = 0;

   // reference state: what the EX stage is holding, in architectural terms
   bit          m_valid;
   logic [31:0] m_a, m_b;
   logic [3:0]  m_sel;
   logic [4:0]  m_rd;
   bit          m_rw, m_mr;
   int          m_bc;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_alu_sel(id_alu_sel), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
      .ex_alu_sel(ex_alu_sel), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 0)                                return rf;
      if (exmem_reg_write && exmem_rd == addr)      return exmem_res;
      if (memwb_reg_write && memwb_rd == addr)      return memwb_data;
      return rf;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_a = 0; m_b = 0; m_sel = 4'hF; m_rd = 0; m_rw = 0; m_mr = 0; m_bc = 0;
   endtask

   task automatic check_outs(input bit all);
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      check("ex_reg_write", 32'(ex_reg_write), 32'(m_valid && m_rw));
      check("ex_mem_read", 32'(ex_mem_read), 32'(m_valid && m_mr));
      check("bubble_cnt", 32'(bubble_cnt), 32'(m_bc));
      if (m_valid || all) begin
         check("ex_a", ex_a, m_a);
         check("ex_b", ex_b, m_b);
         check("ex_alu_sel", 32'(ex_alu_sel), 32'(m_sel));
         check("ex_rd", 32'(ex_rd), 32'(m_rd));
      end
   endtask

   // inputs already driven; check id_ready, advance one edge, check EX outputs
   task automatic step();
      bit hz, rdy, nv;
      logic [31:0] na, nb;
      #1;
      hz  = m_valid && m_mr && m_rd != 0 &&
            (m_rd == id_rs_addr || (!id_use_imm && m_rd == id_rt_addr));
      rdy = (!m_valid || ex_ready) && !hz;
      check("id_ready", 32'(id_ready), 32'(rdy));
      na = operand(id_rs_addr, id_rs_data);
      nb = id_use_imm ? id_imm : operand(id_rt_addr, id_rt_data);
      @(posedge clk);
      #1;
      if (flush) m_valid = 0;
      else if (m_valid && !ex_ready) nv = 1;
      else if (hz) begin
         m_valid = 0;
         if (m_bc < 16'hFFFF) m_bc++;
      end else if (id_valid) begin
         m_valid = 1; m_a = na; m_b = nb; m_sel = id_alu_sel; m_rd = id_rd_addr;
         m_rw = id_reg_write; m_mr = id_mem_read;
      end else m_valid = 0;
      check_outs(0);
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 5;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0; id_alu_sel = 4'b0010;
      id_reg_write = 0; id_mem_read = 0; flush = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_res = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0; ex_ready = 1;
   endtask

   initial begin
      logic [31:0] held_a;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs(1);
      rst = 0;

      // plain capture, no forwarding
      id_valid = 1; id_rs_data = 5; id_rt_data = 7; id_alu_sel = 4'b0010;
      step();
      check("basic_a", ex_a, 32'd5);
      check("basic_b", ex_b, 32'd7);

      // EX/MEM beats MEM/WB, then MEM/WB alone
      id_rs_addr = 3; exmem_reg_write = 1; exmem_rd = 3; exmem_res = 100;
      memwb_reg_write = 1; memwb_rd = 3; memwb_data = 200;
      step();
      check("fwd_exmem", ex_a, 32'd100);
      exmem_reg_write = 0;
      step();
      check("fwd_memwb", ex_a, 32'd200);
      memwb_reg_write = 0;

      // load to r4 then dependent use: one bubble
      id_rs_addr = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1;
      step();
      id_rs_addr = 4; id_rd_addr = 6; id_mem_read = 0; id_rs_data = 9;
      #1 check("lu_ready", 32'(id_ready), 32'd0);
      step();
      check("lu_bubble", 32'(bubble_cnt), 32'd1);
      step();
      check("lu_accept", 32'(ex_valid), 32'd1);

      // downstream stall holds EX, then flush during stall
      held_a = ex_a;
      ex_ready = 0; id_rs_addr = 1; id_rs_data = 32'h55;
      repeat (3) step();
      check("stall_hold_a", ex_a, held_a);
      flush = 1;
      step();
      check("stall_flush", 32'(ex_valid), 32'd0);
      flush = 0; ex_ready = 1;

      // r0 never forwards; immediate selects operand B
      id_rs_addr = 0; id_rs_data = 32'h1234; exmem_reg_write = 1; exmem_rd = 0;
      exmem_res = 32'hDEAD; id_use_imm = 1; id_imm = 32'hFFFF_FFFC;
      step();
      check("r0_a", ex_a, 32'h1234);
      check("imm_b", ex_b, 32'hFFFF_FFFC);
      exmem_reg_write = 0; id_use_imm = 0;

      // asynchronous reset between edges discards the held instruction
      #2 rst = 1;
      #1;
      model_reset();
      check_outs(1);
      @(posedge clk);
      #1;
      check_outs(1);
      rst = 0;

      for (int i = 0; i < 2000; i++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         id_rs_addr = 5'($urandom_range(0, 4));
         id_rt_addr = 5'($urandom_range(0, 4));
         id_rd_addr = 5'($urandom_range(0, 4));
         id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
         id_use_imm = $urandom_range(0, 1) != 0;
         id_alu_sel = 4'($urandom);
         id_reg_write = $urandom_range(0, 1) != 0;
         id_mem_read = $urandom_range(0, 2) == 0;
         flush = $urandom_range(0, 9) == 0;
         exmem_reg_write = $urandom_range(0, 1) != 0;
         exmem_rd = 5'($urandom_range(0, 4)); exmem_res = $urandom;
         memwb_reg_write = $urandom_range(0, 1) != 0;
         memwb_rd = 5'($urandom_range(0, 4)); memwb_data = $urandom;
         ex_ready = $urandom_range(0, 3) != 0;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; one clock domain only.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: id_valid in 1 decoded instruction present; id_ready out 1 stage accepts this cycle.
REQ-004 SHALL have: id_rs_addr, id_rt_addr, id_rd_addr in 5 each; id_rs_data, id_rt_data in 32 each (register-file read values).
REQ-005 SHALL have: id_imm in 32 sign-extended immediate; id_use_imm in 1 selects imm as operand B; id_alu_sel in 4 ALU op code.
REQ-006 SHALL have: id_reg_write in 1, id_mem_read in 1 control bits carried to EX.
REQ-007 SHALL have: flush in 1 discard stage contents (branch taken).
REQ-008 SHALL have: exmem_reg_write in 1, exmem_rd in 5, exmem_res in 32; memwb_reg_write in 1, memwb_rd in 5, memwb_data in 32 (forwarding sources).
REQ-009 SHALL have: ex_ready in 1 ALU stage consumes; ex_valid out 1; ex_a, ex_b out 32 (ALU a, b); ex_alu_sel out 4 (ALU sel); ex_rd out 5; ex_reg_write, ex_mem_read out 1.
REQ-010 SHALL have: bubble_cnt out 16 count of load-use bubbles inserted.

Function
REQ-011 SHALL register one instruction per transfer; transfer occurs on a clk edge when id_valid && id_ready; latency ID->EX outputs exactly 1 cycle.
REQ-012 SHALL drive id_ready = (!ex_valid || ex_ready) && !hazard.
REQ-013 SHALL define hazard = ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == id_rs_addr || (!id_use_imm && ex_rd == id_rt_addr)).
REQ-014 SHALL, on hazard with ex_ready high, clear ex_valid next edge (bubble) and increment bubble_cnt, saturating at 16'hFFFF.
REQ-015 SHALL resolve operand A at capture: exmem_res if exmem_reg_write && exmem_rd == id_rs_addr && exmem_rd != 0; else memwb_data on equivalent MEM/WB match; else id_rs_data.
REQ-016 SHALL resolve rt value with identical priority (EX/MEM over MEM/WB); ex_b = id_imm when id_use_imm, else forwarded rt value.
REQ-017 SHALL never forward for register address 0; reads of r0 yield id_rs_data/id_rt_data unchanged.
REQ-018 SHALL hold all ex_* outputs stable while ex_valid && !ex_ready.
REQ-019 SHALL, when ex_ready && !id_valid && !hazard, clear ex_valid next edge.
REQ-020 SHALL give flush priority: flush high at an edge clears ex_valid, ignores id_valid; bubble_cnt unchanged by flush.
REQ-021 SHALL, when ex_valid is low, drive ex_reg_write = 0 and ex_mem_read = 0 (no side effects from bubbles).
REQ-022 SHALL pass id_alu_sel unchanged; codes 4'b0000-4'b1111 per shared package, no decoding here.

Reset
REQ-023 SHALL, on rst asserted, immediately set ex_valid=0, ex_a=0, ex_b=0, ex_alu_sel=4'b1111, ex_rd=0, ex_reg_write=0, ex_mem_read=0, bubble_cnt=0.
REQ-024 SHALL, with rst asserted mid-transfer, discard the in-flight instruction; first capture possible on first edge after rst deassertion.

Structure
REQ-025 SHALL take data width 32, register-address width 5, ALU op code constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 1001, LUI 1110, ZERO 1111) from shared package datapath_pkg.
REQ-026 SHALL instantiate one combinational sub-module fwd_unit (per-operand source select and mux), used twice (rs, rt).

Verification
REQ-027 SHALL test: rst, then id_rs_data=5, id_rt_data=7, alu_sel=0010, no matches -> next cycle ex_valid=1, ex_a=5, ex_b=7.
REQ-028 SHALL test: id_rs_addr=3, exmem_rd=3 res=100, memwb_rd=3 data=200, both write -> ex_a=100; exmem_reg_write=0 -> ex_a=200.
REQ-029 SHALL test: EX holds lw to r4, next instr rs=4 -> id_ready=0 one cycle, ex_valid=0 next, bubble_cnt=1, then instruction accepted.
REQ-030 SHALL test: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, id_ready=0; flush during stall -> ex_valid=0 next edge.
REQ-031 SHALL test: forwarding match on rd=0 with exmem_res=0xDEAD -> ex_a equals id_rs_data; id_use_imm=1, imm=0xFFFFFFFC -> ex_b=0xFFFFFFFC.
REQ-032 SHALL test: rst asserted between edges while ex_valid=1 -> all outputs at reset values before next edge.
